fas_analysis: RTL and testbench
===============================

Name: fas_analysis

Overview:
- Frequency-analysis back end. Sits directly downstream of the 16-point FFT stage and consumes its 16 parallel complex bins on the single-cycle fft_valid strobe.
- Latches the frame, then computes the power re²+im² of each bin serially, one bin per cycle, through a 2-stage pipeline.
- Reports the index of the strongest bin with a one-cycle done pulse, ready for the next FFT frame every 16 cycles.

Parameters:
- DW, 16, width of each real/imag component (two's complement).
- PW, 32, power width (2*DW); re²+im² ≤ 2^31, so there is no overflow.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- fft_valid  in  1  one-cycle strobe; fft_d0..fft_d15 are valid only in this cycle.
- fft_d0..fft_d15  in  32 each  bin k in natural order; [31:16] real signed, [15:0] imag signed.
- done  out  1  one-cycle pulse; freq is valid in the same cycle.
- freq  out  4  index of the maximum-power bin; held until the next done.
- overrun  out  1  sticky; set when a frame is dropped, cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, done=0, freq=0, overrun=0, all pipeline valids=0. In-flight frames are discarded and no done is produced for them.
- Capture buffer: 16x32 registers, written only when a frame is accepted.
- Frame acceptance:
  - In IDLE: fft_valid is accepted.
  - In SCAN with idx==15: fft_valid is accepted (back-to-back).
  - Otherwise: the frame is dropped, overrun<=1, and the current frame continues unaffected.
- FSM:
  - IDLE -> SCAN on accept; idx<=0.
  - SCAN: idx increments each cycle. At idx==15, go to SCAN with idx<=0 if a frame is accepted that cycle, else go to IDLE.
- Stage 1 (SCAN cycle): select buf[idx]. p = re*re + im*im, computed as signed products with an unsigned PW-bit sum. Register p, idx, and a valid bit.
- Stage 2: on valid with idx_q==0, best<=p and best_idx<=0 unconditionally. Otherwise, if p > best (strict), update best and best_idx.
- When valid with idx_q==15, register done<=1 and freq<=final best_idx. This uses the combinational compare result, so bin 15 is included.
- done is 0 in every other cycle.
- Ties: the lowest index wins. An all-zero frame gives freq=0.
- Latency: fft_valid in cycle T -> done and freq visible in cycle T+18.
- Back-to-back frames 16 cycles apart give dones 16 cycles apart. The pipeline overlaps frames because idx_q==0 reinitialises best.
- -32768 squared = 2^30 is handled exactly (no saturation, no truncation).

Optional Feature:
- Macro: FAS_ANA_MAG_OUT_EN.
- Defined: adds output port max_mag[PW-1:0] = power of the winning bin, registered with freq. It is valid when done=1, holds otherwise, and resets to 0.
- Undefined: the port and its register are absent. freq and done behaviour is identical in both builds.

Test Plan:
1. Bin 5 = {16'sd1000, 16'sd0}, all others 0, fft_valid at T -> done=1 and freq=5 at exactly T+18. done=0 at T+17 and T+19.
2. Bins 3 and 11 both {16'sd300, 16'sd400}, others {16'sd100, 0} -> freq=3 (tie, lowest index). With the macro, max_mag=250000.
3. All bins 0 -> freq=0. Then bin 9 = {-16'sd32768, -16'sd32768} with others {16'sd32767, 0} -> freq=9. With the macro, max_mag=32'h80000000.
4. Frames at T (peak bin 2) and T+16 (peak bin 14) -> done at T+18 with freq=2 and at T+34 with freq=14. overrun stays 0.
5. Frame A at T (peak 7), fft_valid again at T+8 (peak 1) -> A gives freq=7 at T+18, the second frame is dropped, overrun=1 from T+9 and stays set.
6. Frame at T, rst=1 during cycle T+10 -> no done ever appears for it. After reset, freq=0 and overrun=0. A new frame at T+12 gives done at T+30.

Source files
------------

// File: rtl/fas_analysis.sv
// Frequency-analysis back end: latches a 16-bin FFT frame and scans bin powers to find the strongest bin.
// Optional max_mag output (power of the winning bin) is enabled by defining FAS_ANA_MAG_OUT_EN.
module fas_analysis #(
  parameter int DW = 16,
  parameter int PW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
`ifdef FAS_ANA_MAG_OUT_EN
  output logic [PW-1:0]   max_mag,
`endif
  output logic            done,
  output logic [3:0]      freq,
  output logic            overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q;
  logic [3:0]            idx_q;
  logic [2*DW-1:0]       cap_q [16];
  logic [2*DW-1:0]       frame_w [16];

  logic                  accept;
  logic                  drop;

  logic [2*DW-1:0]       sel;
  logic signed [DW-1:0]  re;
  logic signed [DW-1:0]  im;
  logic signed [PW-1:0]  reExt;
  logic signed [PW-1:0]  imExt;
  logic signed [PW-1:0]  reSq;
  logic signed [PW-1:0]  imSq;
  logic [PW-1:0]         p_d;

  logic [PW-1:0]         p_q;
  logic [3:0]            pIdx_q;
  logic                  pValid_q;

  logic [PW-1:0]         best_q;
  logic [3:0]            bestIdx_q;
  logic [PW-1:0]         bestNext;
  logic [3:0]            bestIdxNext;
  logic                  lastBin;

  assign frame_w[0]  = fft_d0;
  assign frame_w[1]  = fft_d1;
  assign frame_w[2]  = fft_d2;
  assign frame_w[3]  = fft_d3;
  assign frame_w[4]  = fft_d4;
  assign frame_w[5]  = fft_d5;
  assign frame_w[6]  = fft_d6;
  assign frame_w[7]  = fft_d7;
  assign frame_w[8]  = fft_d8;
  assign frame_w[9]  = fft_d9;
  assign frame_w[10] = fft_d10;
  assign frame_w[11] = fft_d11;
  assign frame_w[12] = fft_d12;
  assign frame_w[13] = fft_d13;
  assign frame_w[14] = fft_d14;
  assign frame_w[15] = fft_d15;

  // A new frame fits only when idle or on the last scan cycle, giving seamless back-to-back frames.
  assign accept = fft_valid && ((state_q == IDLE) || (idx_q == 4'd15));
  assign drop   = fft_valid && !accept;

  // Sign-extend before squaring so that -32768^2 = 2^30 comes out exact; the sum is unsigned.
  assign sel   = cap_q[idx_q];
  assign re    = sel[2*DW-1:DW];
  assign im    = sel[DW-1:0];
  assign reExt = PW'(re);
  assign imExt = PW'(im);
  assign reSq  = reExt * reExt;
  assign imSq  = imExt * imExt;
  assign p_d   = $unsigned(reSq) + $unsigned(imSq);

  assign lastBin = pValid_q && (pIdx_q == 4'd15);

  always_comb begin
    bestNext    = best_q;
    bestIdxNext = bestIdx_q;
    if (pValid_q) begin
      if (pIdx_q == 4'd0 || p_q > best_q) begin
        bestNext    = p_q;
        bestIdxNext = pIdx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < 16; k++) cap_q[k] <= frame_w[k];
    end
    p_q    <= p_d;
    pIdx_q <= idx_q;

    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      pValid_q  <= 1'b0;
      best_q    <= '0;
      bestIdx_q <= 4'd0;
      done      <= 1'b0;
      freq      <= 4'd0;
      overrun   <= 1'b0;
`ifdef FAS_ANA_MAG_OUT_EN
      max_mag   <= '0;
`endif
    end else begin
      pValid_q  <= (state_q == SCAN);
      best_q    <= bestNext;
      bestIdx_q <= bestIdxNext;
      done      <= lastBin;
      if (lastBin) begin
        freq <= bestIdxNext;
`ifdef FAS_ANA_MAG_OUT_EN
        max_mag <= bestNext;
`endif
      end
      if (drop) overrun <= 1'b1;

      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SCAN;
            idx_q   <= 4'd0;
          end
        end
        SCAN: begin
          if (idx_q == 4'd15) begin
            idx_q <= 4'd0;
            if (!accept) state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fas_analysis.sv
// Scoreboard bench for fas_analysis: frames push expected results, a done-driven monitor pops and compares.
// Build with FAS_ANA_MAG_OUT_EN defined to also check max_mag.
module tb_fas_analysis;

  logic        clk = 1'b0;
  logic        rst;
  logic        fftValid;
  logic [31:0] frameBuf [16];
  logic        done;
  logic [3:0]  freq;
  logic        overrun;
`ifdef FAS_ANA_MAG_OUT_EN
  logic [31:0] maxMag;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  freq;
    logic [31:0] mag;
    int          cyc;
  } exp_t;

  exp_t expQ[$];

  fas_analysis dut (
    .clk(clk), .rst(rst), .fft_valid(fftValid),
    .fft_d0(frameBuf[0]),   .fft_d1(frameBuf[1]),   .fft_d2(frameBuf[2]),   .fft_d3(frameBuf[3]),
    .fft_d4(frameBuf[4]),   .fft_d5(frameBuf[5]),   .fft_d6(frameBuf[6]),   .fft_d7(frameBuf[7]),
    .fft_d8(frameBuf[8]),   .fft_d9(frameBuf[9]),   .fft_d10(frameBuf[10]), .fft_d11(frameBuf[11]),
    .fft_d12(frameBuf[12]), .fft_d13(frameBuf[13]), .fft_d14(frameBuf[14]), .fft_d15(frameBuf[15]),
`ifdef FAS_ANA_MAG_OUT_EN
    .max_mag(maxMag),
`endif
    .done(done), .freq(freq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bin(input int re, input int im);
    logic [15:0] r;
    logic [15:0] i;
    r = 16'(re);
    i = 16'(im);
    return {r, i};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setAll(input logic [31:0] v);
    for (int k = 0; k < 16; k++) frameBuf[k] = v;
  endtask

  // Drives one frame for exactly one cycle; an expectation is queued only for frames the DUT should accept.
  task automatic applyStimulus(input bit expectDone, input logic [3:0] expFreq, input logic [31:0] expMag);
    exp_t e;
    fftValid = 1'b1;
    if (expectDone) begin
      e.freq = expFreq;
      e.mag  = expMag;
      e.cyc  = cyc + 18;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    fftValid = 1'b0;
  endtask

  // Every done pulse must match the oldest queued expectation, including its exact cycle.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("freq", 32'(freq), 32'(e.freq));
        checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef FAS_ANA_MAG_OUT_EN
        checkOutput("max_mag", maxMag, e.mag);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1;
    fftValid = 1'b0;
    setAll(32'd0);
    waitCycles(3);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_freq", 32'(freq), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
`ifdef FAS_ANA_MAG_OUT_EN
    checkOutput("reset_max_mag", maxMag, 32'd0);
`endif
    rst = 1'b0;
    waitCycles(2);

    $display("[TB] single peak in bin 5");
    setAll(32'd0);
    frameBuf[5] = bin(1000, 0);
    applyStimulus(1'b1, 4'd5, 32'd1000000);
    waitCycles(22);

    $display("[TB] tie between bins 3 and 11");
    setAll(bin(100, 0));
    frameBuf[3]  = bin(300, 400);
    frameBuf[11] = bin(300, 400);
    applyStimulus(1'b1, 4'd3, 32'd250000);
    waitCycles(22);

    $display("[TB] all-zero frame then full-scale negative bin 9");
    setAll(32'd0);
    applyStimulus(1'b1, 4'd0, 32'd0);
    waitCycles(15);
    setAll(bin(32767, 0));
    frameBuf[9] = bin(-32768, -32768);
    applyStimulus(1'b1, 4'd9, 32'h80000000);
    waitCycles(22);

    $display("[TB] back-to-back frames");
    setAll(bin(10, 10));
    frameBuf[2] = bin(2000, 0);
    applyStimulus(1'b1, 4'd2, 32'd4000000);
    waitCycles(15);
    setAll(bin(10, 10));
    frameBuf[14] = bin(0, -3000);
    applyStimulus(1'b1, 4'd14, 32'd9000000);
    waitCycles(22);
    checkOutput("overrun_after_b2b", 32'(overrun), 32'd0);

    $display("[TB] overlapping frame is dropped");
    setAll(bin(-20, 30));
    frameBuf[7] = bin(500, 500);
    applyStimulus(1'b1, 4'd7, 32'd500000);
    waitCycles(7);
    checkOutput("overrun_before_drop", 32'(overrun), 32'd0);
    setAll(32'd0);
    frameBuf[1] = bin(5000, 5000);
    applyStimulus(1'b0, 4'd0, 32'd0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    waitCycles(22);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);

    $display("[TB] reset aborts an in-flight frame");
    setAll(32'd0);
    frameBuf[12] = bin(700, 0);
    applyStimulus(1'b1, 4'd12, 32'd490000);
    waitCycles(9);
    rst = 1'b1;
    expQ.delete();
    waitCycles(1);
    rst = 1'b0;
    checkOutput("post_reset_freq", 32'(freq), 32'd0);
    checkOutput("post_reset_overrun", 32'(overrun), 32'd0);
    checkOutput("post_reset_done", 32'(done), 32'd0);
    waitCycles(1);
    setAll(bin(1, 1));
    frameBuf[4] = bin(0, 1234);
    applyStimulus(1'b1, 4'd4, 32'd1522756);

    for (int i = 0; i < 60 && expQ.size() != 0; i++) waitCycles(1);
    waitCycles(5);
    checkOutput("pending_expectations", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
